// File: rtl/status_flag_latch_if.sv
// Status-flag bus between the game controller and the flag latch.
// Latency: none. The interface only carries wires.
// Backpressure: none. Set and clear pulses are sampled on every edge.
interface status_flag_latch_if #(
    parameter int NUM_FLAGS = 11
);
    logic [NUM_FLAGS-1:0] set;
    logic                 clr_a;
    logic                 clr_b;
    logic                 lamp_test;
    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] led;
    logic                 blink_phase;
    logic                 changed;

    // Controller side: drives the pulses and observes the latched state.
    modport master (
        output set, clr_a, clr_b, lamp_test,
        input  flags, led, blink_phase, changed
    );

    // Latch side: consumes the pulses and drives the state and LED outputs.
    modport slave (
        input  set, clr_a, clr_b, lamp_test,
        output flags, led, blink_phase, changed
    );
endinterface

// File: rtl/status_flag_latch.sv
// Sticky status flags with clear groups, an exclusive group, a first-wins group, alert blink and lamp test.
// Latency: flags and changed update one edge after set/clear. led is combinational from the registered state.
// Backpressure: none. Every edge samples the inputs, and pulses between edges are not seen.
module status_flag_latch #(
    parameter int                   NUM_FLAGS         = 11,
    parameter logic [NUM_FLAGS-1:0] CLR_A_MASK        = 11'h21C,
    parameter logic [NUM_FLAGS-1:0] CLR_B_MASK        = 11'h7E0,
    parameter logic [NUM_FLAGS-1:0] EXCL_MASK         = 11'h003,
    parameter logic [NUM_FLAGS-1:0] PRIO_MASK         = 11'h01C,
    parameter logic [NUM_FLAGS-1:0] BLINK_MASK        = 11'h100,
    parameter int                   BLINK_HALF_PERIOD = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    status_flag_latch_if.slave    bus
);
    localparam int                   CW         = $clog2(BLINK_HALF_PERIOD);
    localparam logic [CW-1:0]        CNT_MAX    = CW'(BLINK_HALF_PERIOD - 1);
    localparam logic [NUM_FLAGS-1:0] PLAIN_MASK = ~(EXCL_MASK | PRIO_MASK);

    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic                 changed_q, changed_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    logic [NUM_FLAGS-1:0] clr_vec;
    logic [NUM_FLAGS-1:0] excl_set;
    logic [NUM_FLAGS-1:0] excl_hi;
    logic [NUM_FLAGS-1:0] prio_set;
    logic [NUM_FLAGS-1:0] prio_lo;
    logic [NUM_FLAGS-1:0] excl_next;
    logic [NUM_FLAGS-1:0] prio_next;
    logic                 prio_take;
    logic                 blink_rise;

    // Next flag state. Clear beats set on every bit, and each group resolves its own set pulses.
    always_comb begin
        clr_vec  = ({NUM_FLAGS{bus.clr_a}} & CLR_A_MASK) | ({NUM_FLAGS{bus.clr_b}} & CLR_B_MASK);
        excl_set = bus.set & EXCL_MASK & ~clr_vec;
        prio_set = bus.set & PRIO_MASK;

        // Pick the highest-index exclusive request (the last hit in the loop wins).
        excl_hi = '0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (excl_set[i]) begin
                excl_hi    = '0;
                excl_hi[i] = 1'b1;
            end
        end

        // Pick the lowest-index priority request (the last hit in a downward loop wins).
        prio_lo = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (prio_set[i]) begin
                prio_lo    = '0;
                prio_lo[i] = 1'b1;
            end
        end

        excl_next = ((|excl_set) ? excl_hi : (flags_q & EXCL_MASK)) & ~clr_vec;

        // Accept a new priority winner only when the group is empty and no clear touches it.
        prio_take = ~(|(flags_q & PRIO_MASK)) & ~(|(clr_vec & PRIO_MASK));
        prio_next = (prio_take ? prio_lo : (flags_q & PRIO_MASK)) & ~clr_vec;

        flags_d   = (((flags_q | bus.set) & ~clr_vec) & PLAIN_MASK)
                  | (excl_next & EXCL_MASK)
                  | (prio_next & PRIO_MASK);
        changed_d = (flags_d != flags_q);
    end

    // Blink timebase. A newly latched alert restarts it in the lit phase.
    always_comb begin
        blink_rise = |(flags_d & ~flags_q & BLINK_MASK);
        cnt_d      = cnt_q + 1'b1;
        phase_d    = phase_q;
        if (blink_rise) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
        end else begin
            flags_q   <= flags_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign bus.flags       = flags_q;
    assign bus.changed     = changed_q;
    assign bus.blink_phase = phase_q;
    assign bus.led         = {NUM_FLAGS{bus.lamp_test}} | (flags_q & (~BLINK_MASK | {NUM_FLAGS{phase_q}}));
endmodule

// File: tb/tb_status_flag_latch.sv
// Directed bench for status_flag_latch with a short blink half-period.
// Latency: checks are sampled 1 ns after each rising edge.
// Backpressure: not applicable, so inputs are driven every cycle.
module tb_status_flag_latch;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    status_flag_latch_if #(.NUM_FLAGS(11)) bus ();

    status_flag_latch #(.BLINK_HALF_PERIOD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.set       = '0;
        bus.clr_a     = 1'b0;
        bus.clr_b     = 1'b0;
        bus.lamp_test = 1'b0;
        step();
        step();
        chk("rst_flags", 32'(bus.flags), 32'h000);
        chk("rst_changed", 32'(bus.changed), 32'h0);
        chk("rst_phase", 32'(bus.blink_phase), 32'h1);
        chk("rst_led", 32'(bus.led), 32'h000);
        reset = 1'b0;

        // Exclusive group
        bus.set = 11'h001; step();
        chk("t1_set0", 32'(bus.flags), 32'h001);
        chk("t1_chg", 32'(bus.changed), 32'h1);
        bus.set = 11'h000; step();
        chk("t1_chg_drop", 32'(bus.changed), 32'h0);
        chk("t1_hold", 32'(bus.flags), 32'h001);
        bus.set = 11'h002; step();
        chk("t1_swap", 32'(bus.flags), 32'h002);
        chk("t1_swap_chg", 32'(bus.changed), 32'h1);
        bus.set = 11'h003; step();
        chk("t1_hi_wins", 32'(bus.flags), 32'h002);
        chk("t1_hi_nochg", 32'(bus.changed), 32'h0);
        bus.set = 11'h000;

        // Priority group
        bus.set = 11'h018; step();
        chk("t2_first", 32'(bus.flags), 32'h00A);
        chk("t2_chg", 32'(bus.changed), 32'h1);
        bus.set = 11'h000; step();
        bus.set = 11'h004; step();
        chk("t2_ignored", 32'(bus.flags), 32'h00A);
        chk("t2_nochg", 32'(bus.changed), 32'h0);
        bus.set = 11'h000; bus.clr_a = 1'b1; step();
        chk("t2_clr_a", 32'(bus.flags), 32'h002);
        chk("t2_clr_chg", 32'(bus.changed), 32'h1);
        bus.clr_a = 1'b0;

        // Clear beats set
        bus.set = 11'h7E0; step();
        chk("t3_set", 32'(bus.flags), 32'h7E2);
        bus.set = 11'h020; bus.clr_b = 1'b1; step();
        chk("t3_clr_b", 32'(bus.flags), 32'h002);
        bus.set = 11'h000; bus.clr_b = 1'b0; step();

        // Blink
        bus.set = 11'h100; step();
        bus.set = 11'h000;
        for (int j = 0; j < 12; j++) begin
            logic ph;
            if (j != 0) step();
            ph = ((j / 4) % 2) == 0;
            chk("t4_phase", 32'(bus.blink_phase), 32'(ph));
            chk("t4_led", 32'(bus.led), ph ? 32'h102 : 32'h002);
            chk("t4_flags", 32'(bus.flags), 32'h102);
        end

        // Lamp test
        reset = 1'b1; step(); reset = 1'b0;
        bus.lamp_test = 1'b1; step();
        chk("t5_led", 32'(bus.led), 32'h7FF);
        chk("t5_flags", 32'(bus.flags), 32'h000);
        chk("t5_chg", 32'(bus.changed), 32'h0);
        bus.lamp_test = 1'b0; #1;
        chk("t5_led_off", 32'(bus.led), 32'h000);

        // Reset mid-blink
        bus.set = 11'h100; step();
        bus.set = 11'h000;
        step(); step(); step(); step();
        chk("t6_dark", 32'(bus.blink_phase), 32'h0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_rst_flags", 32'(bus.flags), 32'h000);
        chk("t6_rst_phase", 32'(bus.blink_phase), 32'h1);
        chk("t6_rst_cnt", 32'(dut.cnt_q), 32'h0);
        chk("t6_rst_chg", 32'(bus.changed), 32'h0);
        bus.set = 11'h100; step();
        bus.set = 11'h000;
        chk("t6_reset_chg", 32'(bus.changed), 32'h1);
        for (int j = 0; j < 5; j++) begin
            if (j != 0) step();
            chk("t6_led", 32'(bus.led), (j < 4) ? 32'h100 : 32'h000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
